// File: rtl/sdf_r2_stage_gapped.sv
// sdf_r2_stage_gapped: radix-2 SDF butterfly stage for gapped streams with self-timed drain
module sdf_r2_stage_gapped #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           idata_en,
  input  logic                           idata_sof,
  input  logic [WIDTH-1:0]               idata_r,
  input  logic [WIDTH-1:0]               idata_i,
  input  logic                           scale,
  output logic                           odata_en,
  output logic                           odata_sof,
  output logic [WIDTH-1:0]               odata_r,
  output logic [WIDTH-1:0]               odata_i,
  output logic [$clog2(2*DEPTH)-1:0]     odata_idx,
  output logic                           ovf,
  output logic                           sync_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = WIDTH;

  // returns {clipped, result}: a+b or a-b in W+2 bits, optional rounded halving, then saturation
  function automatic logic [W:0] bf(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic sc);
    logic signed [W+1:0] s, t;
    s = sub ? {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b} : {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b};
    t = sc ? (s + (W+2)'(1)) >>> 1 : s;
    bf = (t[W+1:W-1] == '0 || t[W+1:W-1] == '1) ? {1'b0, t[W-1:0]} : {1'b1, t[W+1], {(W-1){~t[W+1]}}};
  endfunction

  logic [2*W-1:0] mem [DEPTH];
  logic [2*W-1:0] rd, x1, wd;
  logic [AW:0]    k, k_eff;
  logic [AW-1:0]  d, d1, k1;
  logic           drain_act, v1, dr1, fill1, frame_scale, bfly, last, we;
  logic [W-1:0]   ar, ai, br, bi;
  logic [W:0]     p_r, p_i, m_r, m_i;

  assign k_eff = idata_sof ? '0 : k;
  assign bfly  = idata_en & k_eff[AW];
  assign last  = bfly & (&k_eff[AW-1:0]);
  assign {ar, ai} = rd;
  assign {br, bi} = x1;
  assign p_r = bf(ar, br, 1'b0, frame_scale);
  assign p_i = bf(ai, bi, 1'b0, frame_scale);
  assign m_r = bf(ar, br, 1'b1, frame_scale);
  assign m_i = bf(ai, bi, 1'b1, frame_scale);
  assign we  = v1 | fill1;
  assign wd  = v1 ? {m_r[W-1:0], m_i[W-1:0]} : x1;

  // delay buffer: one delayed write port, one read-first synchronous read port
  always_ff @(posedge clock) begin
    if (we) mem[k1] <= wd;
    rd <= mem[drain_act ? d : k_eff[AW-1:0]];
  end

  // input framing, drain sequencing and first pipeline stage
  always_ff @(posedge clock) begin
    if (reset) begin
      k           <= '0;
      d           <= '0;
      d1          <= '0;
      k1          <= '0;
      x1          <= '0;
      drain_act   <= 1'b0;
      v1          <= 1'b0;
      dr1         <= 1'b0;
      fill1       <= 1'b0;
      frame_scale <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      v1    <= bfly;
      fill1 <= idata_en & ~k_eff[AW];
      dr1   <= drain_act;
      d1    <= d;
      if (idata_en) begin
        k  <= k_eff + (AW+1)'(1);
        k1 <= k_eff[AW-1:0];
        x1 <= {idata_r, idata_i};
      end
      if (idata_en & idata_sof & (k != '0)) sync_err <= 1'b1;
      if (idata_en & (k_eff == '0)) frame_scale <= scale;
      if (drain_act) begin
        d <= d + AW'(1);
        if (&d) drain_act <= 1'b0;
      end
      if (last) drain_act <= 1'b1;
    end
  end

  // output register: butterfly sum during BFLY, stored difference during DRAIN
  always_ff @(posedge clock) begin
    if (reset) begin
      odata_en  <= 1'b0;
      odata_sof <= 1'b0;
      odata_r   <= '0;
      odata_i   <= '0;
      odata_idx <= '0;
      ovf       <= 1'b0;
    end else begin
      odata_en  <= v1 | dr1;
      odata_sof <= v1 & (k1 == '0);
      if (v1) begin
        odata_r   <= p_r[W-1:0];
        odata_i   <= p_i[W-1:0];
        odata_idx <= {1'b0, k1};
        ovf       <= ovf | p_r[W] | p_i[W] | m_r[W] | m_i[W];
      end else if (dr1) begin
        {odata_r, odata_i} <= rd;
        odata_idx <= {1'b1, d1};
      end
    end
  end
endmodule

// File: tb/tb_sdf_r2_stage_gapped.sv
// tb_sdf_r2_stage_gapped: directed self-checking bench for the gapped SDF radix-2 stage
module tb_sdf_r2_stage_gapped;
  localparam int D = 4;
  localparam int W = 16;

  logic clock = 0, reset = 1, idata_en = 0, idata_sof = 0, scale = 0;
  logic [W-1:0] idata_r = 0, idata_i = 0, odata_r, odata_i;
  logic odata_en, odata_sof, ovf, sync_err;
  logic [2:0] odata_idx;

  int checks = 0, failures = 0, cnt = 0, t4 = 0;
  logic [W-1:0] xv [8];
  logic [W-1:0] ev [16];
  logic [W-1:0] q_r [$];
  logic [W-1:0] q_i [$];
  logic [2:0]   q_idx [$];
  logic         q_sof [$];
  int           q_t [$];

  sdf_r2_stage_gapped #(.DEPTH(D), .WIDTH(W)) dut (
    .clock(clock), .reset(reset), .idata_en(idata_en), .idata_sof(idata_sof),
    .idata_r(idata_r), .idata_i(idata_i), .scale(scale),
    .odata_en(odata_en), .odata_sof(odata_sof), .odata_r(odata_r), .odata_i(odata_i),
    .odata_idx(odata_idx), .ovf(ovf), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  // cycle stamp, advanced on every rising edge
  always @(posedge clock) cnt <= cnt + 1;

  // collect every valid output on the falling edge
  always @(negedge clock) if (odata_en) begin
    q_r.push_back(odata_r);
    q_i.push_back(odata_i);
    q_idx.push_back(odata_idx);
    q_sof.push_back(odata_sof);
    q_t.push_back(cnt);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic sof, input logic [W-1:0] r, input logic [W-1:0] im, input logic sc);
    idata_en = en; idata_sof = sof; idata_r = r; idata_i = im; scale = sc;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    idata_en = 0; idata_sof = 0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic feed(input bit gap, input bit sc);
    for (int n = 0; n < 8; n++) begin
      step(1'b1, n == 0, xv[n], '0, sc);
      if (n == 4) t4 = cnt;
      if (gap) step(1'b0, 1'b0, '0, '0, 1'b0);
    end
    idata_en = 0; idata_sof = 0;
  endtask

  task automatic ramp(input int m, input int base);
    for (int n = 0; n < 8; n++) xv[n] = W'(m * n);
    for (int j = 0; j < 4; j++) begin
      ev[base+j]   = W'(m * (4 + 2*j));
      ev[base+4+j] = W'(-4 * m);
    end
  endtask

  task automatic check_frame(input int n, input int base, input string tag);
    chk($sformatf("%s_count", tag), q_r.size(), n);
    for (int j = base; j < n; j++) if (j < q_r.size()) begin
      chk($sformatf("%s_r%0d", tag, j), q_r[j], ev[j-base]);
      chk($sformatf("%s_i%0d", tag, j), q_i[j], 0);
      chk($sformatf("%s_idx%0d", tag, j), q_idx[j], (j-base) % 8);
      chk($sformatf("%s_sof%0d", tag, j), q_sof[j], ((j-base) % 8) == 0);
    end
  endtask

  task automatic clr();
    q_r.delete(); q_i.delete(); q_idx.delete(); q_sof.delete(); q_t.delete();
  endtask

  initial begin
    idle(2);
    reset = 0;
    chk("rst_en", odata_en, 0);
    chk("rst_sof", odata_sof, 0);
    chk("rst_r", odata_r, 0);
    chk("rst_i", odata_i, 0);
    chk("rst_idx", odata_idx, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sync", sync_err, 0);

    ramp(1, 0);
    feed(1'b0, 1'b0);
    idle(12);
    check_frame(8, 0, "t1");
    chk("t1_start", q_t[0], t4 + 1);
    chk("t1_span", q_t[7] - q_t[0], 7);
    clr();

    feed(1'b1, 1'b0);
    idle(12);
    check_frame(8, 0, "t2");
    chk("t2_gap", q_t[1] - q_t[0], 2);
    chk("t2_join", q_t[4] - q_t[3], 1);
    chk("t2_drain", q_t[7] - q_t[4], 3);
    chk("t2_ovf", ovf, 0);
    chk("t2_sync", sync_err, 0);
    clr();

    xv = '{16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0};
    ev[0] = 16'h7FFF;
    for (int j = 1; j < 8; j++) ev[j] = '0;
    feed(1'b0, 1'b0);
    idle(12);
    check_frame(8, 0, "t3sat");
    chk("t3sat_ovf", ovf, 1);
    clr();
    reset = 1;
    idle(1);
    reset = 0;
    chk("t3_ovf_rst", ovf, 0);

    xv = '{16'h7FFF, 16'hFFFF, 16'h0001, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0};
    ev[0] = 16'h7FFF; ev[1] = 16'h0; ev[2] = 16'h1; ev[3] = 16'h0;
    ev[4] = 16'h0;    ev[5] = 16'h0; ev[6] = 16'h1; ev[7] = 16'h0;
    feed(1'b0, 1'b1);
    idle(12);
    check_frame(8, 0, "t3scl");
    chk("t3scl_ovf", ovf, 0);
    clr();

    ramp(1, 0);
    feed(1'b0, 1'b0);
    ramp(10, 8);
    feed(1'b0, 1'b0);
    idle(14);
    check_frame(16, 0, "t4");
    chk("t4_span", q_t[15] - q_t[0], 15);
    chk("t4_sync", sync_err, 0);
    clr();

    ramp(1, 0);
    for (int n = 0; n < 5; n++) step(1'b1, n == 0, xv[n], '0, 1'b0);
    feed(1'b0, 1'b0);
    idle(12);
    chk("t5_y0_r", q_r[0], 4);
    chk("t5_y0_idx", q_idx[0], 0);
    chk("t5_y0_sof", q_sof[0], 1);
    check_frame(9, 1, "t5");
    chk("t5_sync", sync_err, 1);
    clr();

    ramp(1, 0);
    feed(1'b0, 1'b0);
    idle(2);
    reset = 1;
    idle(1);
    chk("t6_en", odata_en, 0);
    chk("t6_r", odata_r, 0);
    chk("t6_idx", odata_idx, 0);
    chk("t6_sof", odata_sof, 0);
    chk("t6_sync", sync_err, 0);
    reset = 0;
    idle(10);
    chk("t6_cut", q_r.size(), 5);
    clr();
    ramp(10, 0);
    feed(1'b0, 1'b0);
    idle(12);
    check_frame(8, 0, "t6");
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdf_r2_stage_gapped.md
# sdf_r2_stage_gapped

Radix-2 single-path delay-feedback butterfly stage for the streaming FFT pipeline. It accepts a gapped (non-continuous) complex sample stream framed by a start-of-frame flag. It emits butterfly results in natural SDF order, with a per-frame selectable divide-by-2 scaling and saturation. The trailing half-frame drains autonomously, so no dummy input is needed. The stage sits between stage-level twiddle multipliers, and its output index drives the downstream twiddle address.

## Interface
- DEPTH, 32: delay length D; frame length is 2D; power of two, ≥2
- WIDTH, 16: two's-complement data width per component
- clock  in  1  master clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- idata_en  in  1  input sample valid; may be low on any cycle
- idata_sof  in  1  first sample of frame; qualified by idata_en
- idata_r, idata_i  in  WIDTH each  input sample
- scale  in  1  sampled with the first sample of a frame; 1 = scale by 1/2 with rounding, 0 = saturate
- odata_en  out  1  output valid
- odata_sof  out  1  high with odata_idx==0
- odata_r, odata_i  out  WIDTH each  output sample
- odata_idx  out  log2(2D)  position of the output sample within the output frame
- ovf  out  1  sticky saturation flag
- sync_err  out  1  sticky flag; set when a frame is restarted mid-frame

## Operation
- Input counter k (0..2D-1) advances only on accepted samples (idata_en=1).
- idata_en with idata_sof forces k=0.
- Without idata_sof, k wraps from 2D-1 to 0, so consecutive frames need no sof.
- FILL phase (k<D): write x[k] to the buffer at address k. No output.
- BFLY phase (k≥D): read a = buf[k-D]; b = x[k].
  - Emit y0 = a+b with odata_idx = k-D.
  - Write y1 = a-b to buf[k-D].
- Buffer read-during-write to the same address returns the old contents.
- DRAIN phase: starts the cycle after sample k=2D-1 is accepted.
  - Reads buf[d] for d = 0..D-1, one per clock regardless of idata_en.
  - Emits y1[d] with odata_idx = D+d.
- DRAIN overlaps the FILL of the next frame. Fill writes address k ≤ d, so drained data is never overwritten, and the BFLY of the next frame cannot start before DRAIN ends. There is no backpressure and no input is ever dropped.
- Arithmetic: compute s = a±b in WIDTH+1 bits, separately for each component.
  - scale=1: out = (s+1)>>>1, an arithmetic shift. Never overflows.
  - scale=0: out = s saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any clipped component sets ovf.
- The scale value latched at k=0 applies to all y0 and y1 of that frame, including its DRAIN.
- sof accepted while k≠0:
  - Set sync_err; the partial frame is discarded.
  - If it arrives in BFLY, the y0 already emitted stays emitted and no DRAIN is started for that frame.
  - A DRAIN already in progress from the previous frame completes.
- ovf and sync_err clear only on reset.

## Timing
- All outputs are registered.
- Reset values: odata_en=0, odata_sof=0, odata_r=0, odata_i=0, odata_idx=0, ovf=0, sync_err=0. Counters are idle and DRAIN is inactive; buffer contents are don't-care.
- Latency: BFLY sample accepted at edge n → y0 on outputs after edge n+1.
- DRAIN read d=0 occurs in the cycle after the last sample's edge, and y1[0] is valid one cycle after y0[D-1]. With gapless input, odata_en is therefore high for 2D consecutive cycles per frame.
- Gapped input during BFLY produces matching gaps in y0; DRAIN output is always D consecutive cycles.
- Reset asserted mid-DRAIN: odata_en=0 from the next cycle, and no further drain output appears.
- Simultaneous DRAIN output and BFLY output cannot occur. The verifier asserts this.

## Test plan
- DEPTH=4, gapless x[n]=n+0j for n=0..7, scale=0:
  - odata_r sequence 4,6,8,10,-4,-4,-4,-4, odata_i all 0, odata_idx 0..7.
  - odata_en high 8 consecutive cycles, starting 1 cycle after sample 4 is accepted.
- Same frame with idata_en high every other cycle: identical values and idx; y0 outputs gapped; drain outputs 4 consecutive cycles.
- Saturation, a=b=0x7FFF real:
  - scale=0 → y0=0x7FFF, ovf=1, y1=0.
  - scale=1 → y0=0x7FFF, ovf stays 0.
  - Rounding with scale=1: a=-1, b=0 → y0=0, y1=0; a=1, b=0 → y0=1, y1=1.
- Two gapless back-to-back frames, second sof on the cycle after the first frame's last sample:
  - 16 outputs, odata_sof on each idx 0, no collision.
  - Second-frame values are correct, proving fill does not corrupt the drain.
- sof at k=5:
  - sync_err=1, k restarts at 0.
  - No drain outputs for the aborted frame; the next full frame's outputs are correct.
- reset held one cycle during DRAIN at d=2: all outputs 0 from the next cycle, then a fresh frame is processed correctly.
